// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops are combinational. MUL/DIVU/REMU run on a
// one-bit-per-cycle sequencer and hold busy high until the result is ready.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            stg_clk,
  input  logic            reset,
  input  logic            stg_ena,
  input  logic            stg_x,
  input  logic            in_valid,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            save_to_reg_in,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] c,
  output logic            save_to_reg,
  output logic            busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] o,
                                            input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y);
    logic [SHW-1:0] sh;
    sh = y[SHW-1:0];
    case (o)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_SLL:  return x << sh;
      OP_SRL:  return x >> sh;
      OP_SRA:  return $signed(x) >>> sh;
      OP_SLT:  return {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: return {{(XLEN-1){1'b0}}, (x < y)};
      default: return {XLEN{1'b0}};
    endcase
  endfunction

  state_t          state_r, state_s;
  logic [3:0]      op_r;
  logic [XLEN-1:0] acc_r, rem_r, opnd_r, res_r;
  logic [SHW-1:0]  cnt_r;

  logic            is_multi_s, legal_s, start_s;
  logic [XLEN:0]   rem_sh_s, diff_s;
  logic [XLEN-1:0] acc_step_s, rem_step_s, opnd_step_s, res_step_s;

  // MUL: acc += multiplicand when multiplier LSB set. DIV: restoring subtract,
  // quotient bits shift into acc from the right while dividend bits leave its MSB.
  always_comb begin
    rem_sh_s    = {rem_r, acc_r[XLEN-1]};
    diff_s      = rem_sh_s - {1'b0, opnd_r};
    acc_step_s  = acc_r;
    rem_step_s  = rem_r;
    opnd_step_s = opnd_r;
    if (op_r == OP_MUL) begin
      acc_step_s  = acc_r + (opnd_r[0] ? rem_r : {XLEN{1'b0}});
      rem_step_s  = rem_r << 1;
      opnd_step_s = opnd_r >> 1;
    end else if (!diff_s[XLEN]) begin
      acc_step_s = {acc_r[XLEN-2:0], 1'b1};
      rem_step_s = diff_s[XLEN-1:0];
    end else begin
      acc_step_s = {acc_r[XLEN-2:0], 1'b0};
      rem_step_s = rem_sh_s[XLEN-1:0];
    end
    case (op_r)
      OP_MUL:  res_step_s = acc_step_s;
      OP_DIVU: res_step_s = acc_step_s;
      OP_REMU: res_step_s = rem_step_s;
      default: res_step_s = {XLEN{1'b0}};
    endcase
  end

  // Next state and all outputs; flush overrides every transition.
  always_comb begin
    is_multi_s  = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    legal_s     = (op <= OP_REMU);
    start_s     = (state_r == IDLE) && in_valid && is_multi_s && !stg_x;
    state_s     = state_r;
    busy        = 1'b0;
    c           = {XLEN{1'b0}};
    rd          = 5'd0;
    save_to_reg = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
        c = alu_f(op, a, b);
      end
      RUN: begin
        if (cnt_r == {SHW{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (stg_ena) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
        c = res_r;
      end
      default: state_s = IDLE;
    endcase
    if (stg_x) begin
      state_s = IDLE;
    end else begin
      busy = start_s || (state_r == RUN);
    end
    if (reset) begin
      busy = 1'b0;
      c    = {XLEN{1'b0}};
    end else begin
      rd          = rd_in;
      save_to_reg = in_valid && save_to_reg_in && !busy && !stg_x && legal_s;
    end
  end

  // State register and sequencer datapath.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= 4'd0;
      acc_r   <= {XLEN{1'b0}};
      rem_r   <= {XLEN{1'b0}};
      opnd_r  <= {XLEN{1'b0}};
      res_r   <= {XLEN{1'b0}};
      cnt_r   <= {SHW{1'b0}};
    end else begin
      state_r <= state_s;
      if (start_s) begin
        op_r   <= op;
        cnt_r  <= SHW'(XLEN - 1);
        acc_r  <= (op == OP_MUL) ? {XLEN{1'b0}} : a;
        rem_r  <= (op == OP_MUL) ? b : {XLEN{1'b0}};
        opnd_r <= (op == OP_MUL) ? a : b;
      end else if ((state_r == RUN) && !stg_x) begin
        acc_r  <= acc_step_s;
        rem_r  <= rem_step_s;
        opnd_r <= opnd_step_s;
        cnt_r  <= cnt_r - SHW'(1);
        if (cnt_r == {SHW{1'b0}}) begin
          res_r <= res_step_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        stg_clk = 1'b0;
  logic        reset, stg_ena, stg_x, in_valid, save_to_reg_in;
  logic [3:0]  op;
  logic [31:0] a, b, c;
  logic [4:0]  rd_in, rd;
  logic        save_to_reg, busy;
  int          checks = 0;
  int          failures = 0;

  alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
    .stg_clk(stg_clk), .reset(reset), .stg_ena(stg_ena), .stg_x(stg_x),
    .in_valid(in_valid), .op(op), .a(a), .b(b), .rd_in(rd_in),
    .save_to_reg_in(save_to_reg_in), .rd(rd), .c(c),
    .save_to_reg(save_to_reg), .busy(busy)
  );

  always #5 stg_clk = ~stg_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint unsigned p;
    case (o)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return x << y[4:0];
      4'd6:  return x >> y[4:0];
      4'd7:  return $signed(x) >>> y[4:0];
      4'd8:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:  return (x < y) ? 32'd1 : 32'd0;
      4'd10: begin p = longint'(x) * longint'(y); return p[31:0]; end
      4'd11: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      4'd12: return (y == 32'd0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic s, input logic e, input logic f);
    in_valid = v; op = o; a = x; b = y; rd_in = r; save_to_reg_in = s; stg_ena = e; stg_x = f;
  endtask

  task automatic single_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic v, input logic s, input logic f);
    logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    @(posedge stg_clk); #1;
    drive(v, o, x, y, r, s, 1'b1, f);
    @(negedge stg_clk);
    check("single_c", c, ref_alu(o, x, y));
    check("single_busy", 32'(busy), 32'd0);
    check("single_save", 32'(save_to_reg), 32'(v & s & ~f & (o < 4'd13)));
    check("single_rd", 32'(rd), 32'(r));
  endtask

  // Counts busy cycles from the issue cycle, then checks the DONE-cycle result.
  task automatic wait_result(input logic [31:0] e);
    int n;
    n = 0;
    @(negedge stg_clk);
    while (busy === 1'b1 && n < 40) begin
      n++;
      check("save_while_busy", 32'(save_to_reg), 32'd0);
      @(negedge stg_clk);
    end
    check("busy_cycles", 32'(n), 32'd33);
    check("multi_c", c, e);
    check("multi_save", 32'(save_to_reg), 32'd1);
  endtask

  task automatic idle_probe(input logic [31:0] e);
    @(posedge stg_clk); #1;
    drive(1'b0, 4'd0, e, 32'd1, 5'd3, 1'b1, 1'b1, 1'b0);
    @(negedge stg_clk);
    check("idle_after_c", c, e + 32'd1);
    check("idle_after_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_multi(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
    logic [31:0] e;
    e = ref_alu(o, x, y);
    @(posedge stg_clk); #1;
    drive(1'b1, o, x, y, 5'd9, 1'b1, (hold == 0), 1'b0);
    wait_result(e);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge stg_clk); #1;
        a = $urandom; b = $urandom;
        @(negedge stg_clk);
        check("hold_c", c, e);
        check("hold_busy", 32'(busy), 32'd0);
      end
      @(posedge stg_clk); #1;
      stg_ena = 1'b1;
      a = x; b = y;
    end
    idle_probe(e);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [3:0]  o;
    reset = 1'b1;
    drive(1'b1, 4'd0, 32'd1, 32'd2, 5'd7, 1'b1, 1'b1, 1'b0);
    #12;
    check("reset_c", c, 32'd0);
    check("reset_rd", 32'(rd), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_save", 32'(save_to_reg), 32'd0);
    @(posedge stg_clk); #1;
    reset = 1'b0;

    single_op(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0);
    single_op(4'd1, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0);
    single_op(4'd7, 32'h8000_0000, 32'h24, 1'b1, 1'b1, 1'b0);
    single_op(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0);
    single_op(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0);
    single_op(4'd14, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 200; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0: x = 32'h8000_0000;
        1: x = 32'hFFFF_FFFF;
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      single_op(o, x, y, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 7) == 0));
    end

    run_multi(4'd10, 32'd7, 32'd6, 0);
    run_multi(4'd11, 32'd100, 32'd7, 0);
    run_multi(4'd12, 32'd100, 32'd7, 0);
    run_multi(4'd11, $urandom, 32'd0, 0);
    run_multi(4'd12, 32'd9, 32'd0, 0);
    run_multi(4'd10, 32'd7, 32'd6, 5);

    for (int i = 0; i < 8; i++) begin
      o = 4'($urandom_range(10, 12));
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1, 2: y = 32'($urandom_range(1, 100));
        default: y = $urandom;
      endcase
      run_multi(o, x, y, $urandom_range(0, 3));
    end

    // Flush during RUN cycle 10 of a DIVU.
    @(posedge stg_clk); #1;
    drive(1'b1, 4'd11, 32'd1000, 32'd3, 5'd4, 1'b1, 1'b1, 1'b0);
    @(negedge stg_clk);
    check("flush_issue_busy", 32'(busy), 32'd1);
    repeat (9) begin
      @(posedge stg_clk); @(negedge stg_clk);
      check("flush_run_busy", 32'(busy), 32'd1);
      check("flush_run_save", 32'(save_to_reg), 32'd0);
    end
    @(posedge stg_clk); #1;
    stg_x = 1'b1;
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_save", 32'(save_to_reg), 32'd0);
    @(posedge stg_clk); #1;
    drive(1'b0, 4'd0, 32'd5, 32'd6, 5'd4, 1'b1, 1'b1, 1'b0);
    @(negedge stg_clk);
    check("flush_idle_c", c, 32'd11);
    check("flush_idle_busy", 32'(busy), 32'd0);
    run_multi(4'd10, 32'd3, 32'd3, 0);

    // Reset mid-RUN, then the held MUL restarts from issue.
    @(posedge stg_clk); #1;
    drive(1'b1, 4'd10, 32'd7, 32'd6, 5'd9, 1'b1, 1'b1, 1'b0);
    repeat (5) @(posedge stg_clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_c", c, 32'd0);
    check("rst_run_save", 32'(save_to_reg), 32'd0);
    check("rst_run_rd", 32'(rd), 32'd0);
    @(posedge stg_clk); @(posedge stg_clk); #1;
    reset = 1'b0;
    wait_result(32'd42);
    idle_probe(32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
